uio_uart_tx: RTL

Byte-wide UART transmitter (8 data bits, no parity, 1 or 2 stop bits, LSB first) that drives one bidirectional pad of the tile as an output. It is the send-side counterpart of the tile's input path: on-chip logic hands it bytes through a valid/ready handshake, and it serialises them onto a pin with its output enable asserted. A one-byte holding register lets the next byte be accepted while the current frame shifts out, so back-to-back frames have no idle gap.

---
 rtl/uio_uart_tx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uio_uart_tx.sv
// uio_uart_tx: byte-wide UART transmitter (8N1 or 8N2, LSB first) driving one
// bidirectional tile pad as an output.
//
// A one-byte holding register sits in front of the shifter so that the next
// byte can be accepted while the current frame shifts out. This allows
// back-to-back frames with no idle gap between them.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//   STOP_BITS    : number of stop bits (1 or 2)
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   in_data  : byte to send, sampled on an accepting edge
//   in_valid : in_data is offered
//   in_ready : holding register empty; accept on in_valid && in_ready
//   tx       : serial line, idle/stop level 1
//   tx_oe    : pad output enable, 0 in reset, 1 from the first edge after reset
//   busy     : frame in progress or byte waiting in the holding register
module uio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       tx_oe,
    output logic       busy
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(7);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        hold_data_q, hold_data_d;
    logic              hold_valid_q, hold_valid_d;
    logic [7:0]        shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tx_q, tx_d;
    logic              tx_oe_q, tx_oe_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;
    logic              accept_c;
    logic              bit_done_c;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            idx_q        <= '0;
            tx_q         <= 1'b1;
            tx_oe_q      <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            idx_q        <= idx_d;
            tx_q         <= tx_d;
            tx_oe_q      <= tx_oe_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Next-state logic; outputs are computed from the next state so they register in step
    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        idx_d        = idx_q;
        tx_d         = 1'b1;
        tx_oe_d      = 1'b1;
        busy_d       = 1'b0;
        in_ready_d   = 1'b1;

        accept_c   = in_valid && !hold_valid_q;
        bit_done_c = (bit_cnt_q == CNT_LAST);

        // Accept and drain are mutually exclusive: drain needs hold_valid_q=1, accept needs it 0
        if (accept_c) begin
            hold_data_d  = in_data;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    shift_d      = hold_data_q;
                    hold_valid_d = 1'b0;
                    bit_cnt_d    = '0;
                    idx_d        = '0;
                    state_d      = START;
                end
            end
            START: begin
                if (bit_done_c) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done_c) begin
                    bit_cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_done_c) begin
                    bit_cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        // Chain straight into the next start bit when a byte is already held
                        if (hold_valid_q) begin
                            shift_d      = hold_data_q;
                            hold_valid_d = 1'b0;
                            state_d      = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[idx_d];
            default: tx_d = 1'b1;
        endcase

        busy_d     = (state_d != IDLE) || hold_valid_d;
        in_ready_d = !hold_valid_d;
    end

    assign tx       = tx_q;
    assign tx_oe    = tx_oe_q;
    assign busy     = busy_q;
    assign in_ready = in_ready_q;

endmodule
